uart_cmd_rx: RTL
================

Name: uart_cmd_rx

Overview:
- Serial receiver directly upstream of the ADC power control FSM; converts the host RxD line into 8-bit command bytes.
- Fixed frame format: 8N1 (one start bit, 8 data bits LSB first, no parity, one stop bit), 16x oversampling.
- Each good byte is presented on Data with a single-cycle DataValid strobe. Downstream blocks sample Data only when DataValid=1; Data is not meaningful at other times.

Parameters:
- CLK_FREQ, 100_000_000: Clock frequency in Hz.
- BAUD, 115200: Line rate in bit/s.
- OVERSAMPLE, 16: Ticks per bit. Must be a power of 2 and at least 4.
- DIVISOR, round(CLK_FREQ/(BAUD*OVERSAMPLE)): Clock cycles per tick. Derived, not overridden. Elaboration error if below 2.

Ports:
- Clock  in  1  System clock; all logic is on the rising edge.
- Reset  in  1  Asynchronous, active-low reset.
- RxD  in  1  Asynchronous serial input; idles high.
- Data  out  8  Last good received byte.
- DataValid  out  1  One-cycle strobe when Data is updated.
- FramingError  out  1  One-cycle strobe when a stop bit is sampled low.
- Busy  out  1  High while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (Reset=0, asynchronous): Data=8'h00, DataValid=0, FramingError=0, Busy=0, state=IDLE, counters cleared, both synchroniser flops set to 1.
- RxD passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Tick generator: counts 0..DIVISOR-1 and emits a tick on terminal count. It is held at 0 in IDLE and restarts on leaving IDLE, so sample phase is tied to the detected start edge.
- Tick counter: 0..OVERSAMPLE-1, wraps. A mid-bit sample happens on the tick where the count equals OVERSAMPLE/2-1.
- State IDLE:
  - rxs=0 -> START.
  - Otherwise stay.
- State START:
  - At mid-bit, rxs=1 -> IDLE. This is a glitch: no strobe is raised.
  - At mid-bit, rxs=0 -> DATA with bit index 0. The tick counter then continues, so subsequent samples land mid-bit.
- State DATA:
  - At each mid-bit, shift rxs into shift[7], shifting right, so the first bit received ends up as the LSB.
  - After bit index 7 -> STOP.
- State STOP (at mid-bit):
  - rxs=1: Data<=shift and DataValid=1 for exactly the next cycle; go to IDLE immediately. This allows back-to-back frames whose next start edge arrives half a bit later.
  - rxs=0: FramingError=1 for one cycle, Data unchanged; go to BREAK.
- State BREAK: wait until rxs=1, then -> IDLE. A held-low line produces no further strobes.
- Latency: a DataValid rising edge occurs 2 + (9*OVERSAMPLE + OVERSAMPLE/2)*DIVISOR + 1 cycles after the RxD falling edge, ±1 cycle for synchroniser phase.
- DataValid and FramingError are never high together. Neither is asserted twice for one frame.
- Reset asserted mid-frame aborts the frame with no strobe. After release the block waits for a new falling edge. An RxD that is already low at release is treated as a start edge and goes through glitch rejection.
- Data holds its value indefinitely between strobes.

Decomposition:
- Shared package (also used by the ADC power FSM):
  - CMD_ADC_ON = 8'h4F ('O'), CMD_ADC_OFF = 8'h6F ('o').
  - State encoding localparams IDLE/START/DATA/STOP/BREAK.
  - Frame constant DATA_BITS = 8.
- One natural sub-module: uart_baud_tick (parameter DIVISOR; ports Clock, Reset, Enable, Tick). Tick is a one-cycle pulse and the counter clears when Enable=0.

Test Plan (CLK_FREQ=1_600_000, BAUD=25_000, OVERSAMPLE=16 -> DIVISOR=4, 64 cycles/bit):
- Send 8'h4F with a 1-bit idle gap -> Data=8'h4F and DataValid high for exactly 1 cycle, 611±1 cycles after the falling edge. FramingError stays 0. Busy returns to 0.
- Send 8'h4F then 8'h6F back-to-back with no idle between frames -> two DataValid pulses 640±1 cycles apart; Data=8'h4F then 8'h6F.
- Drive RxD low for 20 cycles then high -> no DataValid, no FramingError. Busy high for about 34 cycles, then IDLE. A following 8'h6F frame is received correctly.
- Send 8'hAA with a stop bit of 0, then hold RxD low for 300 cycles -> a single FramingError pulse, no DataValid, Data keeps the previous value 8'h6F. The state stays in BREAK until RxD rises. A following 8'h4F frame is received correctly.
- Assert Reset during bit 4 of an 8'h55 frame, release after 10 cycles while RxD is still mid-frame:
  - All outputs go to 0 asynchronously, with Data=8'h00.
  - No strobe occurs for the aborted frame (any false start caused by a low data bit is rejected or ends in FramingError).
  - A clean 8'h4F frame afterwards is received correctly.
- Send all 256 byte values in random order with random 0–3 bit idle gaps -> every byte is reproduced exactly, with one DataValid per frame and zero FramingError.

Source files
------------

// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the command UART receiver and the ADC power FSM.
// Holds the command byte codes, the frame width and the receiver state
// encoding, plus the tick divisor calculation used at elaboration.
package uart_cmd_rx_pkg;

  localparam logic [7:0] CMD_ADC_ON  = 8'h4F;
  localparam logic [7:0] CMD_ADC_OFF = 8'h6F;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int calc_divisor(input int clk_freq, input int baud,
                                      input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Receiver-side bundle: serial input plus the received byte and its strobes.
//   RxD          serial line, idles high
//   Data         last good received byte
//   DataValid    one-cycle strobe when Data is updated
//   FramingError one-cycle strobe when a stop bit is sampled low
//   Busy         high while a frame is in progress
// master: the line driver / byte consumer; slave: the receiver.
interface uart_cmd_rx_if;
  logic       RxD;
  logic [7:0] Data;
  logic       DataValid;
  logic       FramingError;
  logic       Busy;

  modport master (output RxD, input Data, DataValid, FramingError, Busy);
  modport slave  (input RxD, output Data, DataValid, FramingError, Busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator. Counts 0..DIVISOR-1 while Enable is high and
// pulses Tick for one cycle on the terminal count. Dropping Enable clears
// the count so the tick phase restarts from the next enable.
//   Clock  system clock
//   Reset  asynchronous active-low reset
//   Enable count enable; counter held at 0 when low
//   Tick   one-cycle pulse every DIVISOR enabled cycles
module uart_baud_tick #(
  parameter int DIVISOR = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  output logic Tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] TC = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!Enable || cnt_q == TC) cnt_d = '0;
    else                        cnt_d = cnt_q + 1'b1;
  end

  assign Tick = Enable && (cnt_q == TC);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 command receiver with 16x (configurable) oversampling. Converts the
// host RxD line into bytes for the ADC power FSM.
//   Clock  system clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    slave side of uart_cmd_rx_if (RxD in; Data, DataValid,
//          FramingError, Busy out)
//
// state | meaning
// IDLE  | line idle, waiting for a low level on rxs
// START | confirming the start bit at its mid-point (glitch rejection)
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit; high -> byte out, low -> framing error
// BREAK | line held low after a bad stop bit, waiting for it to go high
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  uart_cmd_rx_if.slave  bus
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [OW-1:0] MID     = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (DIVISOR < 2) begin : g_div_chk
    $error("uart_cmd_rx: DIVISOR below 2, clock too slow for BAUD*OVERSAMPLE");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_chk
    $error("uart_cmd_rx: OVERSAMPLE must be a power of 2 and at least 4");
  end

  logic                 rx_meta_q, rxs_q;
  rx_state_e            state_q, state_d;
  logic [OW-1:0]        os_cnt_q, os_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 busy_q, busy_d;
  logic                 tick, mid_bit;

  // Tick phase restarts on every exit from IDLE, locking sampling to the
  // detected start edge.
  uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud_tick (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (state_q != IDLE),
    .Tick   (tick)
  );

  assign mid_bit = tick && (os_cnt_q == MID);

  always_comb begin
    state_d         = state_q;
    os_cnt_d        = os_cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    data_d          = data_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;

    // Free-running wrap keeps later samples on the mid-bit phase found
    // during START.
    if (tick) os_cnt_d = os_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        os_cnt_d  = '0;
        bit_idx_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (mid_bit) begin
          if (rxs_q) state_d = IDLE;
          else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        // Return to IDLE at mid-stop so a start edge half a bit later is seen.
        if (mid_bit) begin
          if (rxs_q) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_meta_q       <= 1'b1;
      rxs_q           <= 1'b1;
      state_q         <= IDLE;
      os_cnt_q        <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      rx_meta_q       <= bus.RxD;
      rxs_q           <= rx_meta_q;
      state_q         <= state_d;
      os_cnt_q        <= os_cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.Data         = data_q;
  assign bus.DataValid    = data_valid_q;
  assign bus.FramingError = framing_error_q;
  assign bus.Busy         = busy_q;

endmodule
